// File: rtl/ctl_fsm_wait.sv
// Control FSM for the accumulator CPU: fetch/decode/execute with a memory-ready wait,
// timeout bus error, HLT/SKZ opcodes, run/stop control and a retired-instruction counter.
module ctl_fsm_wait #(
  parameter int OP_W     = 5,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             ena,
  input  logic             run,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic [OP_W-1:0]  optcode,
  output logic             inc_pc,
  output logic             load_acc,
  output logic             load_pc,
  output logic             rd,
  output logic             wr,
  output logic             load_ir,
  output logic             datactl_ena,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  localparam logic [OP_W-1:0] OP_HLT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ANDD = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ORR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDA  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STO  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_XORR = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SKZ  = OP_W'(9);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_INC    = 3'd2,
    S_DECODE = 3'd3,
    S_OPER   = 3'd4,
    S_EXEC   = 3'd5,
    S_POST   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WC_W-1:0]   r_wcnt;
  logic [WC_W-1:0]   w_wcnt_next;
  logic              w_wait;
  logic              w_err;
  logic              w_memop;
  logic              w_sto;
  logic              w_jmp;
  logic              w_skz;
  logic              w_hlt;

  logic              w_inc_pc, w_load_acc, w_load_pc, w_rd, w_wr, w_load_ir, w_datactl, w_halted;
  logic              r_inc_pc, r_load_acc, r_load_pc, r_rd, r_wr, r_load_ir, r_datactl, r_halted;
  logic              r_bus_err;
  logic [CNT_W-1:0]  r_retired;

  always_comb begin
    w_memop = optcode inside {OP_ADD, OP_SUB, OP_ANDD, OP_ORR, OP_XORR, OP_LDA};
    w_sto   = (optcode == OP_STO);
    w_jmp   = (optcode == OP_JMP);
    w_skz   = (optcode == OP_SKZ);
    w_hlt   = (optcode == OP_HLT);
  end

  always_comb begin
    w_next = r_state;
    w_wait = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH: begin
        w_wait = 1'b1;
        if (mem_ready) w_next = S_INC;
      end
      S_INC:    w_next = S_DECODE;
      S_DECODE: w_next = w_hlt ? S_HALT : S_OPER;
      S_OPER:   w_next = S_EXEC;
      S_EXEC: begin
        if (w_memop || w_sto) begin
          w_wait = 1'b1;
          if (mem_ready) w_next = S_POST;
        end else begin
          w_next = S_POST;
        end
      end
      S_POST:   w_next = run ? S_FETCH : S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
    // This cycle would be the WAIT_MAX-th without mem_ready: abort to HALT.
    if (w_wait && !mem_ready && (r_wcnt == WC_W'(WAIT_MAX - 1))) begin
      w_err  = 1'b1;
      w_next = S_HALT;
    end
  end

  always_comb begin
    if (w_next != r_state)
      w_wcnt_next = '0;
    else if (w_wait && !mem_ready)
      w_wcnt_next = r_wcnt + WC_W'(1);
    else
      w_wcnt_next = r_wcnt;
  end

  // Outputs are those of the state being entered, so they change with the state.
  always_comb begin
    w_inc_pc   = 1'b0;
    w_load_acc = 1'b0;
    w_load_pc  = 1'b0;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_load_ir  = 1'b0;
    w_datactl  = 1'b0;
    w_halted   = 1'b0;
    case (w_next)
      S_FETCH: begin
        w_rd      = 1'b1;
        w_load_ir = 1'b1;
      end
      S_INC: begin
        w_inc_pc  = 1'b1;
        w_rd      = 1'b1;
        w_load_ir = 1'b1;
      end
      S_OPER: begin
        w_rd      = w_memop;
        w_datactl = w_sto;
        w_load_pc = w_jmp;
        w_inc_pc  = w_skz && zero;
      end
      S_EXEC: begin
        w_rd       = w_memop;
        w_load_acc = w_memop;
        w_wr       = w_sto;
        w_datactl  = w_sto;
        w_load_pc  = w_jmp;
      end
      S_POST: begin
        w_rd      = w_memop;
        w_datactl = w_sto;
      end
      S_HALT:  w_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(negedge clk or negedge ena) begin
    if (!ena) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_inc_pc   <= 1'b0;
      r_load_acc <= 1'b0;
      r_load_pc  <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_load_ir  <= 1'b0;
      r_datactl  <= 1'b0;
      r_halted   <= 1'b0;
      r_bus_err  <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state    <= w_next;
      r_wcnt     <= w_wcnt_next;
      r_inc_pc   <= w_inc_pc;
      r_load_acc <= w_load_acc;
      r_load_pc  <= w_load_pc;
      r_rd       <= w_rd;
      r_wr       <= w_wr;
      r_load_ir  <= w_load_ir;
      r_datactl  <= w_datactl;
      r_halted   <= w_halted;
      r_bus_err  <= r_bus_err | w_err;
      if (w_next == S_POST && r_state != S_POST)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign inc_pc      = r_inc_pc;
  assign load_acc    = r_load_acc;
  assign load_pc     = r_load_pc;
  assign rd          = r_rd;
  assign wr          = r_wr;
  assign load_ir     = r_load_ir;
  assign datactl_ena = r_datactl;
  assign halted      = r_halted;
  assign bus_err     = r_bus_err;
  assign retired     = r_retired;

endmodule

// File: tb/tb_ctl_fsm_wait.sv
// Bench for ctl_fsm_wait: directed vector table, hand-written corner sequences and
// random instruction streams predicted from an instruction-level trace builder.
module tb_ctl_fsm_wait;
  localparam int OP_W     = 5;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_INC = 2, PH_DEC = 3;
  localparam int PH_OPER = 4, PH_EXEC = 5, PH_POST = 6, PH_HALT = 7;
  localparam int C_NOP = 0, C_MEM = 1, C_STO = 2, C_JMP = 3, C_SKZ = 4, C_HLT = 5;
  localparam int B_INC = 8, B_ACC = 7, B_LPC = 6, B_RD = 5, B_WR = 4;
  localparam int B_IR = 3, B_DCT = 2, B_HLT = 1, B_ERR = 0;

  logic clk = 1'b0;
  logic ena = 1'b0;
  logic run = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic [OP_W-1:0] optcode = '0;
  logic inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halted, bus_err;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] m_ret = '0;
  bit               m_err = 1'b0;

  typedef struct {
    bit              run;
    bit              zero;
    bit              mr;
    logic [OP_W-1:0] op;
    int              ph;
    logic [CNT_W-1:0] ret;
  } vec_t;

  vec_t tbl[64];
  int   ntbl = 0;

  ctl_fsm_wait #(.OP_W(OP_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .ena(ena), .run(run), .zero(zero), .mem_ready(mem_ready),
    .optcode(optcode), .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc),
    .rd(rd), .wr(wr), .load_ir(load_ir), .datactl_ena(datactl_ena),
    .halted(halted), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] got_o();
    return {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halted, bus_err};
  endfunction

  function automatic int cls(input logic [OP_W-1:0] op);
    int v = int'(op);
    if (v == 0) return C_HLT;
    if (v == 1 || v == 2 || v == 3 || v == 4 || v == 5 || v == 8) return C_MEM;
    if (v == 6) return C_STO;
    if (v == 7) return C_JMP;
    if (v == 9) return C_SKZ;
    return C_NOP;
  endfunction

  function automatic logic [8:0] expect_o(input int ph, input logic [OP_W-1:0] op,
                                          input bit z, input bit err);
    logic [8:0] o = '0;
    int c = cls(op);
    case (ph)
      PH_FETCH: begin o[B_RD] = 1; o[B_IR] = 1; end
      PH_INC:   begin o[B_INC] = 1; o[B_RD] = 1; o[B_IR] = 1; end
      PH_OPER: begin
        if (c == C_MEM) o[B_RD] = 1;
        if (c == C_STO) o[B_DCT] = 1;
        if (c == C_JMP) o[B_LPC] = 1;
        if (c == C_SKZ && z) o[B_INC] = 1;
      end
      PH_EXEC: begin
        if (c == C_MEM) begin o[B_RD] = 1; o[B_ACC] = 1; end
        if (c == C_STO) begin o[B_WR] = 1; o[B_DCT] = 1; end
        if (c == C_JMP) o[B_LPC] = 1;
      end
      PH_POST: begin
        if (c == C_MEM) o[B_RD] = 1;
        if (c == C_STO) o[B_DCT] = 1;
      end
      PH_HALT: o[B_HLT] = 1;
      default: ;
    endcase
    o[B_ERR] = err;
    return o;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [OP_W-1:0] rop();
    return OP_W'($urandom);
  endfunction

  task automatic chk(input string nm, input logic [8:0] e, input logic [CNT_W-1:0] er);
    logic [8:0] g = got_o();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s outs(inc,acc,lpc,rd,wr,ir,dct,hlt,err) got=%b exp=%b", nm, g, e);
    end
    checks++;
    if (retired !== er) begin
      errors++;
      $display("FAIL %s retired got=%0d exp=%0d", nm, retired, er);
    end
  endtask

  task automatic cyc(input bit r, input bit z, input bit mr, input logic [OP_W-1:0] op,
                     input int ph, input string nm);
    run = r; zero = z; mem_ready = mr; optcode = op;
    @(negedge clk);
    #1;
    chk(nm, expect_o(ph, op, z, m_err), m_ret);
  endtask

  task automatic do_reset(input string nm);
    ena = 1'b0;
    #2;
    m_ret = '0;
    m_err = 1'b0;
    chk(nm, 9'b0, '0);
    @(negedge clk);
    #1;
    ena = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rb(), rb(), rop(), PH_IDLE, "idle");
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) cyc(rb(), rb(), rb(), rop(), PH_HALT, "halt_hold");
  endtask

  // Builds one instruction's cycle trace: fw/ew are mem_ready=0 cycles in FETCH/EXEC.
  task automatic do_instr(input logic [OP_W-1:0] op, input int fw, input int ew,
                          input bit z, output bit stopped);
    int c = cls(op);
    stopped = 1'b0;
    cyc(1'b1, rb(), rb(), op, PH_FETCH, "fetch");
    for (int i = 0; i < fw; i++) begin
      if (i == WAIT_MAX - 1) begin
        m_err = 1'b1;
        cyc(rb(), rb(), 1'b0, op, PH_HALT, "fetch_timeout");
        stopped = 1'b1;
        return;
      end
      cyc(rb(), rb(), 1'b0, op, PH_FETCH, "fetch_wait");
    end
    cyc(rb(), rb(), 1'b1, op, PH_INC, "inc");
    cyc(rb(), rb(), rb(), op, PH_DEC, "decode");
    if (c == C_HLT) begin
      cyc(rb(), z, rb(), op, PH_HALT, "hlt");
      stopped = 1'b1;
      return;
    end
    cyc(rb(), z, rb(), op, PH_OPER, "oper");
    cyc(rb(), rb(), rb(), op, PH_EXEC, "exec");
    if (c == C_MEM || c == C_STO) begin
      for (int i = 0; i < ew; i++) begin
        if (i == WAIT_MAX - 1) begin
          m_err = 1'b1;
          cyc(rb(), rb(), 1'b0, op, PH_HALT, "exec_timeout");
          stopped = 1'b1;
          return;
        end
        cyc(rb(), rb(), 1'b0, op, PH_EXEC, "exec_wait");
      end
      m_ret = m_ret + 1'b1;
      cyc(rb(), rb(), 1'b1, op, PH_POST, "post");
    end else begin
      m_ret = m_ret + 1'b1;
      cyc(rb(), rb(), rb(), op, PH_POST, "post");
    end
  endtask

  task automatic add(input bit r, input bit z, input bit mr, input int op, input int ph,
                     input int ret);
    tbl[ntbl].run  = r;
    tbl[ntbl].zero = z;
    tbl[ntbl].mr   = mr;
    tbl[ntbl].op   = OP_W'(op);
    tbl[ntbl].ph   = ph;
    tbl[ntbl].ret  = CNT_W'(ret);
    ntbl++;
  endtask

  function automatic int rwait();
    int r = $urandom_range(0, 19);
    if (r < 16) return r % 3;
    if (r < 18) return WAIT_MAX - 1;
    return WAIT_MAX;
  endfunction

  initial begin
    bit st;
    logic [OP_W-1:0] op;

    // Directed table: idle, LDA zero-wait, STO with 3 waits, SKZ z=1/0, JMP, NOP 0x1F.
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, PH_IDLE, 0);
    add(1, 0, 1, 5, PH_FETCH, 0); add(1, 0, 1, 5, PH_INC, 0);  add(1, 0, 1, 5, PH_DEC, 0);
    add(1, 0, 1, 5, PH_OPER, 0);  add(1, 0, 1, 5, PH_EXEC, 0); add(1, 0, 1, 5, PH_POST, 1);
    add(1, 0, 1, 6, PH_FETCH, 1); add(1, 0, 1, 6, PH_INC, 1);  add(1, 0, 1, 6, PH_DEC, 1);
    add(1, 0, 1, 6, PH_OPER, 1);  add(1, 0, 1, 6, PH_EXEC, 1);
    add(0, 0, 0, 6, PH_EXEC, 1);  add(0, 0, 0, 6, PH_EXEC, 1); add(0, 0, 0, 6, PH_EXEC, 1);
    add(1, 0, 1, 6, PH_POST, 2);
    add(1, 0, 1, 9, PH_FETCH, 2); add(1, 0, 1, 9, PH_INC, 2);  add(1, 0, 1, 9, PH_DEC, 2);
    add(1, 1, 1, 9, PH_OPER, 2);  add(1, 0, 1, 9, PH_EXEC, 2); add(1, 0, 1, 9, PH_POST, 3);
    add(1, 0, 1, 9, PH_FETCH, 3); add(1, 1, 1, 9, PH_INC, 3);  add(1, 1, 1, 9, PH_DEC, 3);
    add(1, 0, 1, 9, PH_OPER, 3);  add(1, 1, 1, 9, PH_EXEC, 3); add(1, 1, 1, 9, PH_POST, 4);
    add(1, 0, 1, 7, PH_FETCH, 4); add(1, 0, 1, 7, PH_INC, 4);  add(1, 0, 1, 7, PH_DEC, 4);
    add(1, 0, 0, 7, PH_OPER, 4);  add(1, 0, 0, 7, PH_EXEC, 4); add(1, 0, 0, 7, PH_POST, 5);
    add(1, 0, 1, 31, PH_FETCH, 5); add(1, 0, 1, 31, PH_INC, 5); add(1, 0, 1, 31, PH_DEC, 5);
    add(1, 0, 0, 31, PH_OPER, 5); add(1, 0, 0, 31, PH_EXEC, 5); add(0, 0, 0, 31, PH_POST, 6);
    add(0, 0, 1, 0, PH_IDLE, 6);  add(0, 0, 1, 0, PH_IDLE, 6);

    #2;
    chk("reset_state", 9'b0, '0);
    @(negedge clk);
    #1;
    ena = 1'b1;

    for (int i = 0; i < ntbl; i++) begin
      run = tbl[i].run; zero = tbl[i].zero; mem_ready = tbl[i].mr; optcode = tbl[i].op;
      @(negedge clk);
      #1;
      chk($sformatf("tbl[%0d]", i), expect_o(tbl[i].ph, tbl[i].op, tbl[i].zero, 1'b0),
          tbl[i].ret);
    end

    // HLT: halts after DECODE and ignores run/mem_ready until reset.
    do_reset("reset_before_hlt");
    do_instr(OP_W'(0), 0, 0, 1'b0, st);
    halt_hold(6);

    // FETCH timeout after two retired instructions; retired stays unchanged.
    do_reset("reset_before_fetch_to");
    do_instr(OP_W'(31), 0, 0, 1'b0, st);
    do_instr(OP_W'(2), 0, 1, 1'b0, st);
    do_instr(OP_W'(5), WAIT_MAX, 0, 1'b0, st);
    halt_hold(3);

    // mem_ready on the last allowed FETCH and EXEC cycles: no error.
    do_reset("reset_before_edge_ok");
    do_instr(OP_W'(3), WAIT_MAX - 1, WAIT_MAX - 1, 1'b0, st);
    do_instr(OP_W'(6), 0, WAIT_MAX - 1, 1'b0, st);
    idle_gap(2);

    // EXEC timeout on a store.
    do_instr(OP_W'(6), 0, WAIT_MAX, 1'b0, st);
    halt_hold(2);

    // Reset pulse while a store waits in EXEC.
    do_reset("reset_before_midexec");
    do_instr(OP_W'(8), 0, 0, 1'b0, st);
    cyc(1'b1, 1'b0, 1'b1, OP_W'(6), PH_FETCH, "mx_fetch");
    cyc(1'b1, 1'b0, 1'b1, OP_W'(6), PH_INC, "mx_inc");
    cyc(1'b1, 1'b0, 1'b1, OP_W'(6), PH_DEC, "mx_dec");
    cyc(1'b1, 1'b0, 1'b1, OP_W'(6), PH_OPER, "mx_oper");
    cyc(1'b1, 1'b0, 1'b1, OP_W'(6), PH_EXEC, "mx_exec");
    cyc(1'b1, 1'b0, 1'b0, OP_W'(6), PH_EXEC, "mx_wait");
    do_reset("reset_mid_exec");
    idle_gap(2);

    // Random instruction stream; retired wraps with the narrow counter.
    for (int n = 0; n < 300; n++) begin
      op = rop();
      if (op == '0 && $urandom_range(0, 3) != 0) op = OP_W'(5);
      idle_gap($urandom_range(0, 2));
      do_instr(op, rwait(), rwait(), rb(), st);
      if (st) begin
        halt_hold($urandom_range(1, 3));
        do_reset("reset_after_halt");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
